// File: rtl/ast_dmx_pkg.sv
// Shared types for the Avalon-ST demultiplexer: routing FSM states and beat-width helper.
package ast_dmx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } dmx_state_e;

    // Stored beat layout is {data, sop, eop, empty, channel}.
    function automatic int beat_width(input int data_w, input int empty_w, input int chan_w);
        return data_w + empty_w + chan_w + 2;
    endfunction

endpackage

// File: rtl/ast_fifo.sv
// Single-clock show-ahead FIFO; head entry is presented one cycle after it is written.
module ast_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    import ast_dmx_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             wr_s;
    logic             rd_s;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == {CW{1'b0}});
    assign wr_s    = wr_en && !full;
    assign rd_s    = rd_en && !empty;
    assign rd_data = mem_r[rd_ptr_r];

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_s, rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ast_dmx_fifo.sv
// Avalon-ST 1-to-TX_DIR packet demultiplexer with a show-ahead buffer per output port.
// Optional statistics counters are built when AST_DMX_FIFO_STATS_EN is defined.
module ast_dmx_fifo
    import ast_dmx_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
    parameter int CHANNEL_WIDTH = 10,
    parameter int TX_DIR        = 4,
    parameter int DIR_SEL_WIDTH = $clog2(TX_DIR),
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic [DIR_SEL_WIDTH-1:0] dir_i,
    input  logic [DATA_WIDTH-1:0]    ast_data_i,
    input  logic                     ast_startofpacket_i,
    input  logic                     ast_endofpacket_i,
    input  logic                     ast_valid_i,
    input  logic [EMPTY_WIDTH-1:0]   ast_empty_i,
    input  logic [CHANNEL_WIDTH-1:0] ast_channel_i,
    output logic                     ast_ready_o,
    output logic [DATA_WIDTH-1:0]    ast_data_o          [TX_DIR-1:0],
    output logic                     ast_startofpacket_o [TX_DIR-1:0],
    output logic                     ast_endofpacket_o   [TX_DIR-1:0],
    output logic                     ast_valid_o         [TX_DIR-1:0],
    output logic [EMPTY_WIDTH-1:0]   ast_empty_o         [TX_DIR-1:0],
    output logic [CHANNEL_WIDTH-1:0] ast_channel_o       [TX_DIR-1:0],
    input  logic [TX_DIR-1:0]        ast_ready_i
`ifdef AST_DMX_FIFO_STATS_EN
    ,
    output logic [31:0]              pkt_cnt_o           [TX_DIR-1:0],
    output logic [31:0]              drop_cnt_o
`endif
);

    localparam int BEAT_W = beat_width(DATA_WIDTH, EMPTY_WIDTH, CHANNEL_WIDTH);

    dmx_state_e               state_r;
    logic [DIR_SEL_WIDTH-1:0] dir_r;
    logic [DIR_SEL_WIDTH-1:0] sel_s;
    logic                     in_range_s;
    logic                     full_sel_s;
    logic                     ready_s;
    logic                     route_s;
    logic                     wr_sop_s;
    logic                     accept_s;
    logic                     wr_s;
    logic [TX_DIR-1:0]        full_s;
    logic [TX_DIR-1:0]        empty_s;
    logic [TX_DIR-1:0]        wr_en_s;
    logic [TX_DIR-1:0]        rd_en_s;
    logic [BEAT_W-1:0]        wr_beat_s;
    logic [BEAT_W-1:0]        rd_beat_s [TX_DIR];

    assign in_range_s  = ({1'b0, dir_i} < (DIR_SEL_WIDTH+1)'(TX_DIR));
    assign ast_ready_o = ready_s && !srst_i;
    assign accept_s    = ast_valid_i && ast_ready_o;
    assign wr_s        = accept_s && route_s;
    assign wr_beat_s   = {ast_data_i, wr_sop_s, ast_endofpacket_i, ast_empty_i, ast_channel_i};

    // Full flag of whichever port the current beat would be written to.
    always_comb begin
        full_sel_s = 1'b0;
        for (int k = 0; k < TX_DIR; k++) begin
            full_sel_s = full_sel_s | ((sel_s == DIR_SEL_WIDTH'(k)) & full_s[k]);
        end
    end

    // Port selection, sink ready and write qualification per routing state.
    always_comb begin
        sel_s    = dir_r;
        ready_s  = 1'b0;
        route_s  = 1'b0;
        wr_sop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sel_s    = dir_i;
                ready_s  = in_range_s ? !full_sel_s : 1'b1;
                route_s  = ast_startofpacket_i && in_range_s;
                wr_sop_s = 1'b1;
            end
            ST_FWD: begin
                // A stray SOP inside a packet is carried as a plain continuation beat.
                ready_s  = !full_sel_s;
                route_s  = 1'b1;
                wr_sop_s = 1'b0;
            end
            ST_DROP: begin
                ready_s  = 1'b1;
            end
            default: begin
                ready_s  = 1'b0;
            end
        endcase
    end

    // Routing FSM: latches the destination on SOP and holds it until EOP.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_r <= ST_IDLE;
            dir_r   <= {DIR_SEL_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && ast_startofpacket_i) begin
                        if (in_range_s) begin
                            dir_r   <= dir_i;
                            state_r <= ast_endofpacket_i ? ST_IDLE : ST_FWD;
                        end else begin
                            state_r <= ast_endofpacket_i ? ST_IDLE : ST_DROP;
                        end
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (accept_s && ast_endofpacket_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < TX_DIR; k++) begin : g_port
        assign wr_en_s[k]     = wr_s && (sel_s == DIR_SEL_WIDTH'(k));
        assign ast_valid_o[k] = !empty_s[k];
        assign rd_en_s[k]     = !empty_s[k] && ast_ready_i[k];
        assign {ast_data_o[k], ast_startofpacket_o[k], ast_endofpacket_o[k],
                ast_empty_o[k], ast_channel_o[k]} = rd_beat_s[k];

        ast_fifo #(
            .WIDTH (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk_i),
            .srst    (srst_i),
            .wr_en   (wr_en_s[k]),
            .wr_data (wr_beat_s),
            .rd_en   (rd_en_s[k]),
            .rd_data (rd_beat_s[k]),
            .full    (full_s[k]),
            .empty   (empty_s[k])
        );
    end

`ifdef AST_DMX_FIFO_STATS_EN
    // Per-port packet counts on EOP write; drop count on every discarded SOP, single-beat included.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            for (int k = 0; k < TX_DIR; k++) begin
                pkt_cnt_o[k] <= 32'd0;
            end
            drop_cnt_o <= 32'd0;
        end else begin
            for (int k = 0; k < TX_DIR; k++) begin
                if (wr_en_s[k] && ast_endofpacket_i) begin
                    pkt_cnt_o[k] <= pkt_cnt_o[k] + 32'd1;
                end
            end
            if ((state_r == ST_IDLE) && accept_s && ast_startofpacket_i && !in_range_s) begin
                drop_cnt_o <= drop_cnt_o + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_ast_dmx_fifo.sv
// Self-checking bench for ast_dmx_fifo: directed vector table, corner sequences, random traffic vs queue model.
module tb_ast_dmx_fifo;

    localparam int DW    = 64;
    localparam int EW    = 3;
    localparam int CW    = 10;
    localparam int TXD   = 4;
    localparam int SW    = 3;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic [EW-1:0] e;
        logic [CW-1:0] ch;
    } beat_t;

    typedef struct {
        bit           v;
        bit           sop;
        bit           eop;
        logic [SW-1:0] dir;
        logic [3:0]   rdy;
        bit           exp_ready;
        logic [3:0]   exp_valid;
    } vec_t;

    logic           clk = 1'b0;
    logic           srst;
    logic [SW-1:0]  dir;
    logic [DW-1:0]  data_i;
    logic           sop_i, eop_i, valid_i;
    logic [EW-1:0]  empty_i;
    logic [CW-1:0]  ch_i;
    logic           ready_o;
    logic [DW-1:0]  data_o  [TXD-1:0];
    logic           sop_o   [TXD-1:0];
    logic           eop_o   [TXD-1:0];
    logic           valid_o [TXD-1:0];
    logic [EW-1:0]  empty_o [TXD-1:0];
    logic [CW-1:0]  ch_o    [TXD-1:0];
    logic [TXD-1:0] rdy;
`ifdef AST_DMX_FIFO_STATS_EN
    logic [31:0]    pkt_cnt [TXD-1:0];
    logic [31:0]    drop_cnt;
`endif

    int    total = 0;
    int    passed = 0;
    beat_t mq [TXD][$];
    int    mdest;
    int    mpkt [TXD];
    int    mdrop;
    int    seen [TXD];

    always #5 clk = ~clk;

    ast_dmx_fifo #(
        .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW),
        .TX_DIR(TXD), .DIR_SEL_WIDTH(SW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .srst_i(srst), .dir_i(dir),
        .ast_data_i(data_i), .ast_startofpacket_i(sop_i), .ast_endofpacket_i(eop_i),
        .ast_valid_i(valid_i), .ast_empty_i(empty_i), .ast_channel_i(ch_i),
        .ast_ready_o(ready_o),
        .ast_data_o(data_o), .ast_startofpacket_o(sop_o), .ast_endofpacket_o(eop_o),
        .ast_valid_o(valid_o), .ast_empty_o(empty_o), .ast_channel_o(ch_o),
        .ast_ready_i(rdy)
`ifdef AST_DMX_FIFO_STATS_EN
        , .pkt_cnt_o(pkt_cnt), .drop_cnt_o(drop_cnt)
`endif
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < TXD; k++) begin
            mq[k].delete();
            mpkt[k] = 0;
        end
        mdest = -1;
        mdrop = 0;
    endtask

    // mdest: -1 between packets, -2 discarding a packet, otherwise the port being fed
    function automatic bit model_ready();
        int d = int'(dir);
        if (mdest == -1) return (d < TXD) ? (mq[d].size() < DEPTH) : 1'b1;
        else if (mdest == -2) return 1'b1;
        else return mq[mdest].size() < DEPTH;
    endfunction

    task automatic model_write();
        beat_t b;
        int d = int'(dir);
        b = '{d: data_i, sop: 1'b1, eop: eop_i, e: empty_i, ch: ch_i};
        if (mdest == -1) begin
            if (sop_i) begin
                if (d < TXD) begin
                    mq[d].push_back(b);
                    if (eop_i) mpkt[d]++;
                    else mdest = d;
                end else begin
                    mdrop++;
                    if (!eop_i) mdest = -2;
                end
            end
        end else if (mdest == -2) begin
            if (eop_i) mdest = -1;
        end else begin
            b.sop = 1'b0;
            mq[mdest].push_back(b);
            if (eop_i) begin
                mpkt[mdest]++;
                mdest = -1;
            end
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input logic [SW-1:0] d, input logic [TXD-1:0] r);
        valid_i = v;
        sop_i   = s;
        eop_i   = e;
        dir     = d;
        rdy     = r;
        data_i  = {$urandom(), $urandom()};
        empty_i = EW'($urandom_range(7));
        ch_i    = CW'($urandom_range(1023));
    endtask

    // Called at a negedge with inputs applied; checks outputs, then advances one clock.
    task automatic step(output bit acc, output bit got_rdy, output logic [TXD-1:0] got_vld);
        bit pop [TXD];
        bit mr;
        #1;
        mr = model_ready();
        got_rdy = ready_o;
        chk("ready", ready_o, mr);
        for (int k = 0; k < TXD; k++) begin
            got_vld[k] = valid_o[k];
            chk($sformatf("valid[%0d]", k), valid_o[k], mq[k].size() > 0);
            if (mq[k].size() > 0)
                chk($sformatf("beat[%0d]", k), {data_o[k], sop_o[k], eop_o[k], empty_o[k], ch_o[k]}, mq[k][0]);
            pop[k] = (mq[k].size() > 0) && rdy[k];
        end
        acc = valid_i && mr;
        @(posedge clk);
        for (int k = 0; k < TXD; k++) begin
            if (pop[k]) begin
                void'(mq[k].pop_front());
                seen[k]++;
            end
        end
        if (acc) model_write();
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl [18];
        bit acc, gr;
        logic [TXD-1:0] gv;
        int idx, base [TXD];

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd2, 4'hF, 1'b1, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd2, 4'hF, 1'b1, 4'b0100};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'd2, 4'hF, 1'b1, 4'b0100};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'd2, 4'hF, 1'b1, 4'b0100};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd2, 4'hF, 1'b1, 4'b0000};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd1, 4'hF, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'hF, 1'b1, 4'b0010};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 3'd0, 4'hF, 1'b1, 4'b0010};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 3'd0, 4'hF, 1'b1, 4'b0010};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b1, 4'b0001};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b1, 4'b0000};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd5, 4'hF, 1'b1, 4'b0000};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 3'd5, 4'hF, 1'b1, 4'b0000};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 3'd0, 4'hF, 1'b1, 4'b0000};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 3'd5, 4'hF, 1'b1, 4'b0000};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 1'b1, 4'b0000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 3'd3, 4'hF, 1'b1, 4'b0000};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 3'd3, 4'hF, 1'b1, 4'b0000};

        for (int k = 0; k < TXD; k++) seen[k] = 0;
        srst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 4'hF);
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_valid", {valid_o[3], valid_o[2], valid_o[1], valid_o[0]}, 4'b0000);
        srst = 1'b0;
        @(negedge clk);

        // Directed table: routing, lock across dir change, drop, stray non-SOP
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].dir, tbl[i].rdy);
            step(acc, gr, gv);
            chk($sformatf("tbl%0d.ready", i), gr, tbl[i].exp_ready);
            chk($sformatf("tbl%0d.valid", i), gv, tbl[i].exp_valid);
        end

        // Port 1 stalled: 10-beat packet, only DEPTH beats fit
        idx = 0;
        base[1] = seen[1];
        for (int c = 0; c < 14; c++) begin
            drive(1'b1, idx == 0, idx == 9, 3'd1, 4'b1101);
            step(acc, gr, gv);
            if (acc) idx++;
        end
        chk("stall_accepted", idx, DEPTH);
        chk("stall_ready", gr, 1'b0);
        for (int c = 0; c < 12 && idx < 10; c++) begin
            drive(1'b1, 1'b0, idx == 9, 3'd1, 4'hF);
            step(acc, gr, gv);
            if (acc) idx++;
        end
        chk("stall_all_accepted", idx, 10);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 1'b0, 1'b0, 3'd0, 4'hF);
            step(acc, gr, gv);
        end
        chk("stall_out_count", seen[1] - base[1], 10);

        // Asynchronous reset during beat 2 of a packet to port 3
        drive(1'b1, 1'b1, 1'b0, 3'd3, 4'hF);
        step(acc, gr, gv);
        drive(1'b1, 1'b0, 1'b0, 3'd3, 4'hF);
        #2 srst = 1'b1;
        #1;
        chk("midrst_valid", {valid_o[3], valid_o[2], valid_o[1], valid_o[0]}, 4'b0000);
        chk("midrst_ready", ready_o, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        #2 srst = 1'b0;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 3'd3, 4'hF);
        step(acc, gr, gv);
        drive(1'b0, 1'b0, 1'b0, 3'd3, 4'hF);
        step(acc, gr, gv);
        chk("postrst_nonsop", gv, 4'b0000);
        drive(1'b1, 1'b1, 1'b1, 3'd3, 4'hF);
        step(acc, gr, gv);
        drive(1'b0, 1'b0, 1'b0, 3'd3, 4'hF);
        step(acc, gr, gv);
        chk("postrst_sop", gv, 4'b1000);

        // Back-to-back single-beat packets to each port
        for (int k = 0; k < TXD; k++) base[k] = seen[k];
        for (int k = 0; k < TXD; k++) begin
            drive(1'b1, 1'b1, 1'b1, SW'(k), 4'hF);
            step(acc, gr, gv);
            chk($sformatf("b2b_ready%0d", k), gr, 1'b1);
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 1'b0, 3'd0, 4'hF);
            step(acc, gr, gv);
        end
        for (int k = 0; k < TXD; k++) chk($sformatf("b2b_count%0d", k), seen[k] - base[k], 1);
`ifdef AST_DMX_FIFO_STATS_EN
        for (int k = 0; k < TXD; k++) chk($sformatf("b2b_pkt%0d", k), pkt_cnt[k], mpkt[k]);
        chk("b2b_drop", drop_cnt, mdrop);
`endif

        // Random traffic against the queue model
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
                  SW'($urandom_range(5)), TXD'($urandom_range(15)));
            step(acc, gr, gv);
        end
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b0, 1'b0, 3'd0, 4'hF);
            step(acc, gr, gv);
        end
        for (int k = 0; k < TXD; k++) chk($sformatf("drained%0d", k), mq[k].size(), 0);
`ifdef AST_DMX_FIFO_STATS_EN
        for (int k = 0; k < TXD; k++) chk($sformatf("pkt_cnt%0d", k), pkt_cnt[k], mpkt[k]);
        chk("drop_cnt", drop_cnt, mdrop);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ast_dmx_fifo.md
AST_DMX_FIFO -- requirements
Module: ast_dmx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, 64: data bus width in bits; multiple of 8.
REQ-002 Parameter EMPTY_WIDTH, $clog2(DATA_WIDTH/8): empty field width.
REQ-003 Parameter CHANNEL_WIDTH, 10: channel field width.
REQ-004 Parameter TX_DIR, 4: number of output ports, 2..16.
REQ-005 Parameter DIR_SEL_WIDTH, $clog2(TX_DIR): direction select width.
REQ-006 Parameter FIFO_DEPTH, 8: beats per output buffer; power of 2, >= 2.
REQ-007 clk_i  in  1  single clock; all logic on its rising edge.
REQ-008 srst_i  in  1  asynchronous, active-high reset.
REQ-009 dir_i  in  DIR_SEL_WIDTH  destination port, sampled on the accepted SOP beat only.
REQ-010 ast_data_i/ast_startofpacket_i/ast_endofpacket_i/ast_valid_i/ast_empty_i/ast_channel_i  in  as parameters  Avalon-ST sink.
REQ-011 ast_ready_o  out  1  sink ready.
REQ-012 ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_valid_o, ast_empty_o, ast_channel_o  out  unpacked arrays [TX_DIR-1:0]  Avalon-ST sources.
REQ-013 ast_ready_i  in  [TX_DIR-1:0]  per-source ready.

Function
REQ-014 An input beat is accepted when ast_valid_i && ast_ready_o; an output beat transfers when ast_valid_o[k] && ast_ready_i[k].
REQ-015 Routing FSM states: IDLE, FWD, DROP.
REQ-016 IDLE: accepted SOP with dir_i < TX_DIR latches dir_i and goes to FWD; with dir_i >= TX_DIR goes to DROP; SOP&&EOP beat routes or drops per the same rule and stays IDLE.
REQ-017 IDLE: accepted beat without SOP is discarded; state unchanged.
REQ-018 FWD: every accepted beat is written to the latched port's buffer; accepted EOP returns to IDLE.
REQ-019 FWD: SOP without preceding EOP is a continuation beat of the current packet, its SOP bit forced to 0.
REQ-020 DROP: ast_ready_o = 1, beats discarded; accepted EOP returns to IDLE.
REQ-021 ast_ready_o: IDLE -> !full[dir_i] (1 if dir_i >= TX_DIR); FWD -> !full[latched dir]; DROP -> 1; combinational from state, dir_i and full flags.
REQ-022 Each buffer stores {data, sop, eop, empty, channel}, show-ahead; beat written at edge N is visible at output from cycle N+1.
REQ-023 Simultaneous write and read on a full buffer: write not allowed (ready already 0); on an empty buffer, no write-through bypass (latency stays 1).
REQ-024 Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
REQ-025 One output stalled never blocks another port's packets except while FSM is locked to the stalled port.
REQ-026 ast_data_o/empty/channel are don't-care when ast_valid_o[k] = 0.

Reset
REQ-027 On srst_i assertion: FSM -> IDLE, all pointers/counts 0, ast_valid_o all 0, ast_ready_o 0 while asserted.
REQ-028 Reset mid-packet discards all buffered and in-flight beats; first beat after release must be SOP to be routed.

Configuration
REQ-029 Macro AST_DMX_FIFO_STATS_EN defined: extra outputs pkt_cnt_o[TX_DIR-1:0] (32 bits, packets whose EOP is written per port) and drop_cnt_o (32 bits, packets entering DROP), wrap at 2^32, cleared by reset.
REQ-030 Macro undefined: those ports and counters do not exist; behaviour otherwise identical.

Structure
REQ-031 Shared package ast_dmx_pkg holds the FSM state enum and a parametrised beat struct width helper; defaults stay in the module parameters.
REQ-032 One sub-module ast_fifo (single-clock, show-ahead, width/depth parameters, full/empty flags), instantiated TX_DIR times in a generate loop.

Verification
REQ-033 TX_DIR=4, dir_i=2, 3-beat packet, all ready_i=1 -> beats on port 2 only at cycles N+1..N+3, SOP on beat 1, EOP on beat 3, ports 0/1/3 valid=0.
REQ-034 dir_i changes to 0 mid-packet (locked to 1) -> all beats of packet on port 1; next SOP with dir_i=0 goes to port 0.
REQ-035 ready_i[1]=0, FIFO_DEPTH=8, 10-beat packet to port 1 -> ast_ready_o drops after 8 accepted beats; ready_i[1]=1 releases all 10 in order, none lost.
REQ-036 dir_i=5 with TX_DIR=4, 4-beat packet -> ast_ready_o=1 throughout, no output valid, drop_cnt_o=1 when STATS_EN.
REQ-037 srst_i asserted asynchronously during beat 2 of a packet to port 3 -> valid_o all 0 same cycle; post-release non-SOP beat discarded; next SOP routed normally.
REQ-038 Back-to-back single-beat packets to ports 0,1,2,3 every cycle -> one beat on each port, ast_ready_o stays 1, pkt_cnt_o = {1,1,1,1}.
